store_buffer: RTL and testbench

STORE_BUFFER -- requirements
Module: store_buffer

---
 rtl/store_buffer.sv | 123 ++++++++++++
 tb/tb_store_buffer.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
// Store buffer: circular FIFO of pending stores that drains to memory and forwards to loads.
// Optional macro STB_COALESCE_EN merges a store into the youngest matching non-in-flight entry.
module store_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       st_valid,
  input  logic [ADDR_W-1:0]          st_addr,
  input  logic [DATA_W-1:0]          st_data,
  output logic                       st_ready,
  input  logic                       ld_valid,
  input  logic [ADDR_W-1:0]          ld_addr,
  output logic                       ld_hit,
  output logic [DATA_W-1:0]          ld_data,
  input  logic                       mem_busy,
  output logic                       mem_wr_req,
  output logic [ADDR_W-1:0]          mem_wr_addr,
  output logic [DATA_W-1:0]          mem_wr_data,
  input  logic                       mem_wr_ack,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  typedef enum logic {IDLE, REQ} drainState_t;

  drainState_t       state;
  logic [ADDR_W-1:0] addrMem [DEPTH];
  logic [DATA_W-1:0] dataMem [DEPTH];
  logic [PW-1:0]     head;
  logic [PW-1:0]     tail;
  logic              push;
  logic              alloc;
  logic              pop;
  logic [CW-1:0]     countNext;
  logic              unusedLdLow;

  function automatic logic [PW-1:0] slotOf(input logic [PW-1:0] base, input int unsigned off);
    return base + PW'(off);
  endfunction

  assign empty       = (count == '0);
  assign mem_wr_req  = (state == REQ);
  assign mem_wr_addr = (state == REQ) ? addrMem[head] : '0;
  assign mem_wr_data = (state == REQ) ? dataMem[head] : '0;
  assign push        = st_valid && st_ready;
  assign pop         = (state == REQ) && mem_wr_ack;
  assign countNext   = count + CW'(alloc) - CW'(pop);
  assign unusedLdLow = ^ld_addr[1:0];

  // Scan oldest to youngest so the last match is the youngest one.
  always_comb begin
    ld_hit  = 1'b0;
    ld_data = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (ld_valid && (CW'(i) < count) &&
          addrMem[slotOf(head, i)][ADDR_W-1:2] == ld_addr[ADDR_W-1:2]) begin
        ld_hit  = 1'b1;
        ld_data = dataMem[slotOf(head, i)];
      end
    end
  end

`ifdef STB_COALESCE_EN
  logic          stMatch;
  logic [PW-1:0] stMatchIdx;
  logic          coalesce;

  // The head is excluded only while its write is on the bus.
  always_comb begin
    stMatch    = 1'b0;
    stMatchIdx = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if ((CW'(i) < count) && !(i == 0 && state == REQ) &&
          addrMem[slotOf(head, i)][ADDR_W-1:2] == st_addr[ADDR_W-1:2]) begin
        stMatch    = 1'b1;
        stMatchIdx = slotOf(head, i);
      end
    end
  end

  assign st_ready = (count < CW'(DEPTH)) || stMatch;
  assign alloc    = push && !stMatch;
  assign coalesce = push && stMatch;
`else
  assign st_ready = (count < CW'(DEPTH));
  assign alloc    = push;
`endif

  always_ff @(posedge clk) begin
    if (!reset && alloc) begin
      addrMem[tail] <= st_addr;
      dataMem[tail] <= st_data;
    end
`ifdef STB_COALESCE_EN
    if (!reset && coalesce) dataMem[stMatchIdx] <= st_data;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      state <= IDLE;
    end else begin
      if (alloc) tail <= tail + PW'(1);
      if (pop)   head <= head + PW'(1);
      count <= countNext;
      case (state)
        IDLE: if (count != '0 && !mem_busy) state <= REQ;
        REQ:  if (mem_wr_ack) state <= (countNext != '0 && !mem_busy) ? REQ : IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: stimulus queues expected writes/loads, a monitor checks them.
module tb_store_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        st_valid;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        st_ready;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic        ld_hit;
  logic [31:0] ld_data;
  logic        mem_busy;
  logic        mem_wr_req;
  logic [31:0] mem_wr_addr;
  logic [31:0] mem_wr_data;
  logic        mem_wr_ack;
  logic [2:0]  count;
  logic        empty;

  int total = 0;
  int bad   = 0;

  logic [63:0] expWr [$];
  logic [32:0] expLd [$];

  always #5 clk = ~clk;

  store_buffer #(.DEPTH(4), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_ready(st_ready),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_hit(ld_hit), .ld_data(ld_data),
    .mem_busy(mem_busy), .mem_wr_req(mem_wr_req), .mem_wr_addr(mem_wr_addr),
    .mem_wr_data(mem_wr_data), .mem_wr_ack(mem_wr_ack),
    .count(count), .empty(empty)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    st_valid = 1'b1;
    st_addr  = a;
    st_data  = d;
  endtask

  task automatic drainAll();
    int n;
    n = 0;
    mem_wr_ack = 1'b1;
    while (n < 40) begin
      sample();
      if (empty && !mem_wr_req) break;
      nextCycle();
      n++;
    end
    total++;
    if (n >= 40) begin
      bad++;
      $display("FAIL drain_timeout: got count=%0d expected 0", count);
    end
    mem_wr_ack = 1'b0;
    nextCycle();
  endtask

  task automatic doReset();
    reset = 1'b1;
    nextCycle();
    reset = 1'b0;
    expWr.delete();
  endtask

  // Monitor: each completed write and each load lookup is checked against the queues.
  always @(negedge clk) begin
    if (!reset && mem_wr_req && mem_wr_ack) begin
      total++;
      if (expWr.size() == 0) begin
        bad++;
        $display("FAIL wr_unexpected: got %0h/%0h expected none", mem_wr_addr, mem_wr_data);
      end else begin
        logic [63:0] e;
        e = expWr.pop_front();
        if ({mem_wr_addr, mem_wr_data} !== e) begin
          bad++;
          $display("FAIL wr_order: got %0h/%0h expected %0h/%0h",
                   mem_wr_addr, mem_wr_data, e[63:32], e[31:0]);
        end
      end
    end
    if (ld_valid && expLd.size() != 0) begin
      logic [32:0] l;
      l = expLd.pop_front();
      total++;
      if ({ld_hit, ld_data} !== l) begin
        bad++;
        $display("FAIL ld_lookup: got hit=%0b data=%0h expected hit=%0b data=%0h",
                 ld_hit, ld_data, l[32], l[31:0]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; st_valid = 1'b0; st_addr = '0; st_data = '0;
    ld_valid = 1'b0; ld_addr = '0; mem_busy = 1'b0; mem_wr_ack = 1'b0;
    nextCycle();
    nextCycle();
    reset = 1'b0;

    // reset state
    ld_valid = 1'b1; ld_addr = 32'h10;
    sample();
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_req", mem_wr_req, 0);
    chk("rst_hit", ld_hit, 0);
    chk("rst_ldata", ld_data, 0);
    chk("rst_waddr", mem_wr_addr, 0);
    chk("rst_ready", st_ready, 1);
    nextCycle();
    ld_valid = 1'b0;

    // single store, ack on third REQ cycle
    store(32'h10, 32'h11);
    expWr.push_back({32'h10, 32'h11});
    sample();
    chk("t1_req_c0", mem_wr_req, 0);
    nextCycle();
    st_valid = 1'b0;
    sample();
    chk("t1_count1", count, 1);
    chk("t1_req_c1", mem_wr_req, 0);
    nextCycle();
    for (int k = 0; k < 3; k++) begin
      mem_wr_ack = (k == 2);
      sample();
      chk("t1_req_hold", mem_wr_req, 1);
      chk("t1_addr_hold", mem_wr_addr, 32'h10);
      chk("t1_data_hold", mem_wr_data, 32'h11);
      nextCycle();
    end
    mem_wr_ack = 1'b0;
    sample();
    chk("t1_count0", count, 0);
    chk("t1_req_off", mem_wr_req, 0);
    nextCycle();

    // five back-to-back stores with no ack: fifth refused
    for (int k = 0; k < 5; k++) begin
      store(32'h100 + 32'(4 * k), 32'hC0 + 32'(k));
      if (k < 4) expWr.push_back({32'h100 + 32'(4 * k), 32'hC0 + 32'(k)});
      sample();
      if (k == 4) begin
        chk("t2_ready_full", st_ready, 0);
        chk("t2_count_full", count, 4);
      end
      nextCycle();
    end
    st_valid = 1'b0;
    sample();
    chk("t2_count_after", count, 4);
    nextCycle();
    drainAll();

    // two stores to one word, then forwarding lookups
    store(32'h20, 32'hAA);
    nextCycle();
    store(32'h20, 32'hBB);
    nextCycle();
    st_valid = 1'b0;
`ifdef STB_COALESCE_EN
    expWr.push_back({32'h20, 32'hBB});
`else
    expWr.push_back({32'h20, 32'hAA});
    expWr.push_back({32'h20, 32'hBB});
`endif
    ld_valid = 1'b1; ld_addr = 32'h22;
    expLd.push_back({1'b1, 32'hBB});
    sample();
`ifdef STB_COALESCE_EN
    chk("t3_count", count, 1);
`else
    chk("t3_count", count, 2);
`endif
    nextCycle();
    ld_addr = 32'h30;
    expLd.push_back({1'b0, 32'h0});
    nextCycle();
    ld_valid = 1'b0; ld_addr = 32'h20;
    sample();
    chk("t3_noload_hit", ld_hit, 0);
    nextCycle();
    drainAll();

    // full buffer with ack and store together; tail wraps
    doReset();
    for (int k = 0; k < 4; k++) begin
      store(32'h200 + 32'(4 * k), 32'hD0 + 32'(k));
      expWr.push_back({32'h200 + 32'(4 * k), 32'hD0 + 32'(k)});
      nextCycle();
    end
    store(32'h300, 32'hD4);
    mem_wr_ack = 1'b1;
    sample();
    chk("t4_ready_full", st_ready, 0);
    chk("t4_count_full", count, 4);
    nextCycle();
    expWr.push_back({32'h300, 32'hD4});
    sample();
    chk("t4_ready_room", st_ready, 1);
    chk("t4_count3a", count, 3);
    nextCycle();
    store(32'h304, 32'hD5);
    expWr.push_back({32'h304, 32'hD5});
    sample();
    chk("t4_count3b", count, 3);
    nextCycle();
    st_valid = 1'b0; mem_wr_ack = 1'b0;
    sample();
    chk("t4_count3c", count, 3);
    nextCycle();
    drainAll();

    // mem_busy blocks a drain start but not one in progress
    mem_busy = 1'b1;
    store(32'h400, 32'hE0);
    expWr.push_back({32'h400, 32'hE0});
    nextCycle();
    store(32'h404, 32'hE1);
    expWr.push_back({32'h404, 32'hE1});
    nextCycle();
    st_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      sample();
      chk("t5_busy_noreq", mem_wr_req, 0);
      chk("t5_busy_count", count, 2);
      nextCycle();
    end
    mem_busy = 1'b0;
    sample();
    chk("t5_req_lat", mem_wr_req, 0);
    nextCycle();
    mem_busy = 1'b1;
    sample();
    chk("t5_req_on", mem_wr_req, 1);
    nextCycle();
    mem_wr_ack = 1'b1;
    sample();
    chk("t5_req_kept", mem_wr_req, 1);
    chk("t5_req_addr", mem_wr_addr, 32'h400);
    nextCycle();
    mem_wr_ack = 1'b0;
    sample();
    chk("t5_busy_idle", mem_wr_req, 0);
    chk("t5_count1", count, 1);
    nextCycle();
    mem_busy = 1'b0;
    drainAll();

    // reset while a write is pending with three entries
    for (int k = 0; k < 3; k++) begin
      store(32'h500 + 32'(4 * k), 32'hF0 + 32'(k));
      nextCycle();
    end
    st_valid = 1'b0;
    sample();
    chk("t6_req_pend", mem_wr_req, 1);
    chk("t6_count3", count, 3);
    nextCycle();
    reset = 1'b1;
    store(32'h600, 32'hF9);
    nextCycle();
    reset = 1'b0; st_valid = 1'b0;
    expWr.delete();
    mem_wr_ack = 1'b1;
    sample();
    chk("t6_count_rst", count, 0);
    chk("t6_req_rst", mem_wr_req, 0);
    chk("t6_empty_rst", empty, 1);
    nextCycle();
    mem_wr_ack = 1'b0;
    sample();
    chk("t6_late_ack", count, 0);
    chk("t6_late_req", mem_wr_req, 0);
    nextCycle();

    chk("end_wr_queue", 64'(expWr.size()), 0);
    chk("end_ld_queue", 64'(expLd.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
